// File: rtl/bisipo_pkg.sv
// Shared types and constants for the bisipo transfer controller.
package bisipo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic DIR_LEFT  = 1'b1;
    localparam logic DIR_RIGHT = 1'b0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer favours the requester not served last.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       idx
);

    logic prio;

    always_comb begin
        idx = 1'b0;
        if (valid[0] && valid[1]) begin
            idx = prio;
        end else if (valid[1]) begin
            idx = 1'b1;
        end
        grant = {idx, ~idx} & {2{|valid}};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= ~idx;
        end
    end

endmodule

// File: rtl/bisipo_ctrl.sv
// Arbitrates two word requesters, serialises the granted word into a bisipo
// shift register and reports the captured parallel output with a match flag.
module bisipo_ctrl
    import bisipo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    input  logic             req0_left,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    input  logic             req1_left,
    output logic             req1_ready,
    output logic             sr_reset,
    output logic             sr_left,
    output logic             sr_din,
    input  logic [WIDTH-1:0] sr_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_src,
    output logic             out_match
);

    localparam int unsigned CW = $clog2(WIDTH);

    state_t           state;
    state_t           state_nxt;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    bit_idx;
    logic [WIDTH-1:0] lat_data;
    logic             lat_left;
    logic             lat_src;
    logic [1:0]       grant;
    logic             gidx;
    logic             idle;
    logic             accept;
    logic             last_bit;

    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .valid   ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant),
        .idx     (gidx)
    );

    assign idle       = (state == IDLE) && !reset;
    assign req0_ready = idle && grant[0];
    assign req1_ready = idle && grant[1];
    assign accept     = req0_ready || req1_ready;
    assign last_bit   = (cnt == CW'(WIDTH - 1));
    // Left shifts feed the MSB first, right shifts the LSB first.
    assign bit_idx    = (lat_left == DIR_LEFT) ? (CW'(WIDTH - 1) - cnt) : cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        sr_reset  = reset;
        sr_left   = 1'b0;
        sr_din    = 1'b0;
        out_valid = 1'b0;
        if (!reset) begin
            unique case (state)
                IDLE: begin
                    if (accept) state_nxt = CLEAR;
                end
                CLEAR: begin
                    sr_reset  = 1'b1;
                    state_nxt = SHIFT;
                end
                SHIFT: begin
                    sr_left = lat_left;
                    sr_din  = lat_data[bit_idx];
                    if (last_bit) state_nxt = CAPTURE;
                end
                CAPTURE: begin
                    state_nxt = DONE;
                end
                DONE: begin
                    out_valid = 1'b1;
                    if (out_ready) state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Request latch, bit counter and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            lat_data  <= '0;
            lat_left  <= DIR_RIGHT;
            lat_src   <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
            out_match <= 1'b0;
        end else begin
            if (accept) begin
                lat_data <= gidx ? req1_data : req0_data;
                lat_left <= gidx ? req1_left : req0_left;
                lat_src  <= gidx;
            end
            if (state == SHIFT) begin
                cnt <= last_bit ? '0 : cnt + CW'(1);
            end
            if (state == CAPTURE) begin
                out_data  <= sr_q;
                out_src   <= lat_src;
                out_match <= (sr_q == lat_data);
            end
        end
    end

endmodule
